// File: rtl/cnn_frame_loader.sv
// rtl/cnn_frame_loader.sv - pixel stream to frame buffer loader and CNN core run/result sequencer
module cnn_frame_loader #(
    parameter int DATA_W  = 32,
    parameter int NPIX    = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_last,
    output logic [NPIX*DATA_W-1:0]   img_flat,
    output logic                     core_clr,
    output logic                     core_enable,
    input  logic                     core_done,
    input  logic signed [DATA_W-1:0] core_value,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [DATA_W-1:0] res_data,
    output logic                     err_len,
    output logic                     err_timeout,
    output logic [15:0]              frame_cnt
);

    localparam int CW = $clog2(NPIX);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);
    localparam logic [TW-1:0] TLIM     = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {LOAD, DRAIN, CLEAR, RUN, RESULT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] pix_cnt, pix_cnt_n;
    logic [TW-1:0] timer, timer_n;
    logic          err_len_n, err_to_n, wr_en, capture, deliver;

    wire beat = s_valid && s_ready;

    always_comb begin
        state_n   = state;
        pix_cnt_n = pix_cnt;
        timer_n   = timer;
        err_len_n = 1'b0;
        err_to_n  = 1'b0;
        wr_en     = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        case (state)
            LOAD: begin
                if (beat) begin
                    wr_en     = 1'b1;
                    pix_cnt_n = pix_cnt + 1'b1;
                    if (s_last) begin
                        pix_cnt_n = '0;
                        if (pix_cnt == LAST_IDX) state_n = CLEAR;
                        else                     err_len_n = 1'b1;
                    end else if (pix_cnt == LAST_IDX) begin
                        // Frame overran the buffer: keep the 64th pixel, drop the rest
                        pix_cnt_n = '0;
                        err_len_n = 1'b1;
                        state_n   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat && s_last) begin
                    pix_cnt_n = '0;
                    state_n   = LOAD;
                end
            end
            CLEAR: begin
                timer_n = '0;
                state_n = RUN;
            end
            RUN: begin
                timer_n = timer + 1'b1;
                // A done arriving on the last allowed cycle still counts as success
                if (core_done) begin
                    capture = 1'b1;
                    state_n = RESULT;
                end else if ((TIMEOUT != 0) && (timer == TLIM)) begin
                    err_to_n = 1'b1;
                    state_n  = LOAD;
                end
            end
            RESULT: begin
                if (res_valid && res_ready) begin
                    deliver = 1'b1;
                    state_n = LOAD;
                end
            end
            default: state_n = LOAD;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= LOAD;
            pix_cnt     <= '0;
            timer       <= '0;
            img_flat    <= '0;
            s_ready     <= 1'b0;
            core_clr    <= 1'b1;
            core_enable <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_n;
            pix_cnt     <= pix_cnt_n;
            timer       <= timer_n;
            s_ready     <= (state_n == LOAD) || (state_n == DRAIN);
            core_clr    <= (state_n == CLEAR);
            core_enable <= (state_n == RUN);
            res_valid   <= (state_n == RESULT);
            err_len     <= err_len_n;
            err_timeout <= err_to_n;
            if (wr_en)   img_flat[pix_cnt*DATA_W +: DATA_W] <= s_data;
            if (capture) res_data <= core_value;
            if (deliver) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cnn_frame_loader.sv
// tb/tb_cnn_frame_loader.sv - directed self-checking bench for cnn_frame_loader
module tb_cnn_frame_loader;
    localparam int DW = 32;
    localparam int NP = 64;
    localparam int CORE_DLY = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                 s_valid = 1'b0, s_last = 1'b0, res_ready = 1'b0;
    logic signed [DW-1:0] s_data = '0;
    logic                 core_done = 1'b0;
    logic signed [DW-1:0] core_val = '0;
    bit                   hang = 1'b0;
    int                   core_cnt = 0;

    logic                 s_ready, core_clr, core_enable, res_valid, err_len, err_timeout;
    logic [NP*DW-1:0]     img_flat;
    logic signed [DW-1:0] res_data;
    logic [15:0]          frame_cnt;

    logic                 s_ready_t, core_clr_t, core_enable_t, res_valid_t, err_len_t, err_timeout_t;
    logic [NP*DW-1:0]     img_flat_t;
    logic signed [DW-1:0] res_data_t;
    logic [15:0]          frame_cnt_t;

    cnn_frame_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .img_flat(img_flat), .core_clr(core_clr), .core_enable(core_enable),
        .core_done(core_done), .core_value(core_val), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .err_len(err_len),
        .err_timeout(err_timeout), .frame_cnt(frame_cnt)
    );

    cnn_frame_loader #(.TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_t), .s_data(s_data),
        .s_last(s_last), .img_flat(img_flat_t), .core_clr(core_clr_t),
        .core_enable(core_enable_t), .core_done(1'b0), .core_value(32'sd0),
        .res_valid(res_valid_t), .res_ready(res_ready), .res_data(res_data_t),
        .err_len(err_len_t), .err_timeout(err_timeout_t), .frame_cnt(frame_cnt_t)
    );

    // Core model: done rises so that enable is seen high for CORE_DLY cycles
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_done <= 1'b0;
            core_cnt  <= 0;
        end else if (core_clr) begin
            core_done <= 1'b0;
            core_cnt  <= 0;
        end else if (core_enable && !core_done && !hang) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == CORE_DLY - 2) core_done <= 1'b1;
        end
    end

    int n_errlen = 0, n_clr = 0, n_en = 0;
    always @(negedge clk) begin
        if (err_len) n_errlen++;
        if (core_clr && rst) n_clr++;
        if (core_enable) n_en++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] slot(input logic [NP*DW-1:0] f, input int k);
        return f[k*DW +: DW];
    endfunction

    task automatic send_frame(input int n, input int last_idx, input int base,
                              output int errlen_at, output bit ok);
        int w;
        errlen_at = -1;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(base + i);
            s_last  = (i == last_idx);
            w = 0;
            while (!s_ready && w < 100) begin
                tick();
                w++;
            end
            if (!s_ready) begin
                ok = 1'b0;
                break;
            end
            tick();
            if (err_len && errlen_at < 0) errlen_at = i;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_result(output bit ok);
        int w;
        w = 0;
        while (!res_valid && w < 500) begin
            tick();
            w++;
        end
        ok = res_valid;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %0h want 0", s_ready); end
        n_cmp++; if (core_clr !== 1'b1) begin n_bad++; $display("FAIL rst_core_clr: got %0h want 1", core_clr); end
        n_cmp++; if (core_enable !== 1'b0 || res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_en_valid: got %0h/%0h want 0/0", core_enable, res_valid); end
        n_cmp++; if (img_flat !== '0 || res_data !== '0 || frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_regs: res_data %0h frame_cnt %0h want 0", res_data, frame_cnt); end
        n_cmp++; if (err_len !== 1'b0 || err_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0h/%0h want 0/0", err_len, err_timeout); end
        rst = 1'b1;
        tick();
        n_cmp++; if (s_ready !== 1'b1 || core_clr !== 1'b0) begin n_bad++; $display("FAIL rst_release: s_ready %0h core_clr %0h want 1/0", s_ready, core_clr); end
    endtask

    task automatic test_nominal();
        int ea, en, w;
        bit ok;
        core_val = 32'sh0000_00AB;
        send_frame(64, 63, 1, ea, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL nom_accept: got stalled want accepted"); end
        n_cmp++; if (core_clr !== 1'b1 || s_ready !== 1'b0) begin n_bad++; $display("FAIL nom_clr: core_clr %0h s_ready %0h want 1/0", core_clr, s_ready); end
        n_cmp++; if (slot(img_flat, 5) !== 32'd6 || slot(img_flat, 0) !== 32'd1 || slot(img_flat, 63) !== 32'd64) begin n_bad++; $display("FAIL nom_img: slot5 %0h slot0 %0h slot63 %0h want 6/1/40", slot(img_flat, 5), slot(img_flat, 0), slot(img_flat, 63)); end
        n_cmp++; if (ea !== -1) begin n_bad++; $display("FAIL nom_errlen: got beat %0d want none", ea); end
        tick();
        n_cmp++; if (core_clr !== 1'b0 || core_enable !== 1'b1) begin n_bad++; $display("FAIL nom_enable: core_clr %0h core_enable %0h want 0/1", core_clr, core_enable); end
        en = 0;
        w = 0;
        while (core_enable && w < 200) begin
            en++;
            tick();
            w++;
        end
        n_cmp++; if (en !== CORE_DLY) begin n_bad++; $display("FAIL nom_en_cycles: got %0d want %0d", en, CORE_DLY); end
        n_cmp++; if (res_valid !== 1'b1 || res_data !== 32'sh0000_00AB) begin n_bad++; $display("FAIL nom_result: valid %0h data %0h want 1/ab", res_valid, res_data); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || frame_cnt !== 16'd1 || s_ready !== 1'b1) begin n_bad++; $display("FAIL nom_handshake: valid %0h frame_cnt %0d s_ready %0h want 0/1/1", res_valid, frame_cnt, s_ready); end
    endtask

    task automatic test_backpressure();
        int ea;
        bit ok;
        core_val = -32'sd5;
        send_frame(64, 63, 100, ea, ok);
        wait_result(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_wait: got no res_valid want res_valid"); end
        s_valid = 1'b1;
        s_data  = 32'sd999;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (res_valid !== 1'b1 || res_data !== -32'sd5 || s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d: valid %0h data %0h s_ready %0h want 1/fffffffb/0", i, res_valid, res_data, s_ready); end
            tick();
        end
        s_valid = 1'b0;
        n_cmp++; if (slot(img_flat, 0) !== 32'd100) begin n_bad++; $display("FAIL bp_frozen: slot0 %0d want 100", slot(img_flat, 0)); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || frame_cnt !== 16'd2 || s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_handshake: valid %0h frame_cnt %0d s_ready %0h want 0/2/1", res_valid, frame_cnt, s_ready); end
    endtask

    task automatic test_short_frame();
        int ea, e0, c0, n0;
        bit ok;
        e0 = n_errlen; c0 = n_clr; n0 = n_en;
        send_frame(11, 10, 200, ea, ok);
        tick(); tick(); tick();
        n_cmp++; if (ea !== 10) begin n_bad++; $display("FAIL short_errlen_beat: got %0d want 10", ea); end
        n_cmp++; if (n_errlen - e0 !== 1 || n_clr - c0 !== 0 || n_en - n0 !== 0) begin n_bad++; $display("FAIL short_pulses: errlen %0d clr %0d en %0d want 1/0/0", n_errlen - e0, n_clr - c0, n_en - n0); end
        n_cmp++; if (s_ready !== 1'b1 || slot(img_flat, 0) !== 32'd200 || slot(img_flat, 11) !== 32'd111) begin n_bad++; $display("FAIL short_state: s_ready %0h slot0 %0d slot11 %0d want 1/200/111", s_ready, slot(img_flat, 0), slot(img_flat, 11)); end
        core_val = 32'sd77;
        send_frame(64, 63, 300, ea, ok);
        wait_result(ok);
        n_cmp++; if (!ok || res_data !== 32'sd77 || slot(img_flat, 11) !== 32'd311) begin n_bad++; $display("FAIL short_next: ok %0d data %0d slot11 %0d want 1/77/311", ok, res_data, slot(img_flat, 11)); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL short_cnt: got %0d want 3", frame_cnt); end
    endtask

    task automatic test_long_frame();
        int ea, e0, c0, n0;
        bit ok;
        e0 = n_errlen; c0 = n_clr; n0 = n_en;
        send_frame(70, 69, 400, ea, ok);
        tick(); tick(); tick();
        n_cmp++; if (!ok || ea !== 63) begin n_bad++; $display("FAIL long_errlen_beat: ok %0d beat %0d want 1/63", ok, ea); end
        n_cmp++; if (n_errlen - e0 !== 1 || n_clr - c0 !== 0 || n_en - n0 !== 0) begin n_bad++; $display("FAIL long_pulses: errlen %0d clr %0d en %0d want 1/0/0", n_errlen - e0, n_clr - c0, n_en - n0); end
        n_cmp++; if (slot(img_flat, 63) !== 32'd463 || slot(img_flat, 0) !== 32'd400) begin n_bad++; $display("FAIL long_img: slot63 %0d slot0 %0d want 463/400", slot(img_flat, 63), slot(img_flat, 0)); end
        n_cmp++; if (s_ready !== 1'b1 || frame_cnt !== 16'd3) begin n_bad++; $display("FAIL long_state: s_ready %0h frame_cnt %0d want 1/3", s_ready, frame_cnt); end
    endtask

    task automatic test_timeout();
        int ea, en, w;
        bit ok;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        hang = 1'b1;
        send_frame(64, 63, 600, ea, ok);
        tick();
        en = 0;
        w = 0;
        while (core_enable_t && w < 200) begin
            en++;
            tick();
            w++;
        end
        n_cmp++; if (en !== 16) begin n_bad++; $display("FAIL to_en_cycles: got %0d want 16", en); end
        n_cmp++; if (err_timeout_t !== 1'b1 || s_ready_t !== 1'b1) begin n_bad++; $display("FAIL to_pulse: err_timeout %0h s_ready %0h want 1/1", err_timeout_t, s_ready_t); end
        n_cmp++; if (frame_cnt_t !== 16'd0 || res_valid_t !== 1'b0) begin n_bad++; $display("FAIL to_noresult: frame_cnt %0d res_valid %0h want 0/0", frame_cnt_t, res_valid_t); end
        tick();
        n_cmp++; if (err_timeout_t !== 1'b0) begin n_bad++; $display("FAIL to_single: got %0h want 0", err_timeout_t); end
    endtask

    task automatic test_reset_mid_run();
        int ea;
        bit ok;
        n_cmp++; if (core_enable !== 1'b1) begin n_bad++; $display("FAIL mid_running: core_enable %0h want 1", core_enable); end
        rst = 1'b0;
        #1;
        n_cmp++; if (core_enable !== 1'b0 || core_clr !== 1'b1 || res_valid !== 1'b0 || s_ready !== 1'b0) begin n_bad++; $display("FAIL mid_async: en %0h clr %0h valid %0h s_ready %0h want 0/1/0/0", core_enable, core_clr, res_valid, s_ready); end
        tick();
        rst = 1'b1;
        hang = 1'b0;
        tick();
        core_val = 32'sh1234;
        send_frame(64, 63, 700, ea, ok);
        wait_result(ok);
        n_cmp++; if (!ok || res_data !== 32'sh1234 || slot(img_flat, 5) !== 32'd705) begin n_bad++; $display("FAIL mid_after: ok %0d data %0h slot5 %0d want 1/1234/705", ok, res_data, slot(img_flat, 5)); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL mid_cnt: got %0d want 1", frame_cnt); end
    endtask

    initial begin
        #1;
        test_reset();
        test_nominal();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_timeout();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule
